// File: rtl/axi_burst_reader_axi3_if.sv
// AXI3 read-address/read-data channel bundle for the framebuffer burst reader.
// The master modport is the reader side; the slave modport is the memory side.
interface axi_burst_reader_axi3_if;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arlen, arsize, arburst, arlock,
    output arcache, arprot, arqos, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arlock,
    input  arcache, arprot, arqos, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_burst_reader_axi3.sv
// Fetches a pixel rectangle from a framebuffer with narrow AXI3 INCR bursts.
// Define AXI_RD_RRESP_CHECK_EN to also flag non-OKAY rresp as an error.
module axi_burst_reader_axi3 #(
  parameter int unsigned STRIDE    = 800,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] framebuffer_baseaddr,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic [10:0] width,
  input  logic [10:0] height,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  pixel_data,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        pixel_eol,
  output logic        pixel_last,
  axi_burst_reader_axi3_if.master M00_AXI
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, NEXT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] araddr_q, araddr_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [10:0] w_q, w_d, h_q, h_d;
  logic [11:0] row_q, row_d;
  logic [11:0] col_q, col_d;
  logic [3:0]  arlen_q, arlen_d;
  logic [3:0]  beat_q, beat_d;
  logic        arvalid_q, arvalid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        idle;
  logic [31:0] s_base;
  logic [10:0] s_x, s_y, s_w;
  logic [11:0] s_row, s_col;
  logic [31:0] row_addr, b_addr;
  logic [12:0] rem, to4k, beats;
  logic [3:0]  plan_len;

  // Planner reads the ports while idle so the first AR is ready in ADDR
  always_comb begin
    idle     = state_q == IDLE;
    s_base   = idle ? framebuffer_baseaddr : base_q;
    s_x      = idle ? pixel_x : x_q;
    s_y      = idle ? pixel_y : y_q;
    s_w      = idle ? width : w_q;
    s_row    = idle ? 12'd0 : row_q;
    s_col    = idle ? 12'd0 : col_q;
    row_addr = s_base
             + ({21'd0, s_y} + {20'd0, s_row}) * 32'(STRIDE)
             + {21'd0, s_x};
    b_addr   = row_addr + {20'd0, s_col};
    rem      = {2'b00, s_w} + 13'd1 - {1'b0, s_col};
    to4k     = 13'h1000 - {1'b0, b_addr[11:0]};
    beats    = 13'(MAX_BEATS);
    if (rem < beats) beats = rem;
    if (to4k < beats) beats = to4k;
    plan_len = 4'(beats - 13'd1);
  end

  logic        hs, exp_last, row_end, at_last_row;
  logic [11:0] end_col;
  logic [1:0]  lane;

  always_comb begin
    hs          = (state_q == DATA) && M00_AXI.rvalid && pixel_ready;
    exp_last    = beat_q == arlen_q;
    end_col     = col_q + {8'd0, arlen_q} + 12'd1;
    row_end     = end_col == ({1'b0, w_q} + 12'd1);
    at_last_row = row_q == {1'b0, h_q};
    lane        = araddr_q[1:0] + beat_q[1:0];
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    araddr_d  = araddr_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    row_d     = row_q;
    col_d     = col_q;
    arlen_d   = arlen_q;
    beat_d    = beat_q;
    arvalid_d = arvalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    unique case (state_q)
      IDLE: if (start) begin
        base_d    = framebuffer_baseaddr;
        x_d       = pixel_x;
        y_d       = pixel_y;
        w_d       = width;
        h_d       = height;
        row_d     = 12'd0;
        col_d     = 12'd0;
        araddr_d  = b_addr;
        arlen_d   = plan_len;
        arvalid_d = 1'b1;
        busy_d    = 1'b1;
        error_d   = 1'b0;
        state_d   = ADDR;
      end
      ADDR: if (M00_AXI.arready) begin
        arvalid_d = 1'b0;
        beat_d    = 4'd0;
        state_d   = DATA;
      end
      DATA: if (hs) begin
        if (beat_q != 4'hf) beat_d = beat_q + 4'd1;
        if (M00_AXI.rlast != exp_last) error_d = 1'b1;
`ifdef AXI_RD_RRESP_CHECK_EN
        if (M00_AXI.rresp != 2'b00) error_d = 1'b1;
`endif
        // Column advances by the planned length even on a short burst
        if (M00_AXI.rlast) begin
          state_d = NEXT;
          if (row_end) begin
            col_d = 12'd0;
            row_d = row_q + 12'd1;
          end else begin
            col_d = end_col;
          end
        end
      end
      NEXT: if (row_q > {1'b0, h_q}) begin
        done_d  = 1'b1;
        state_d = DONE;
      end else begin
        araddr_d  = b_addr;
        arlen_d   = plan_len;
        arvalid_d = 1'b1;
        state_d   = ADDR;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      araddr_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      arlen_q   <= '0;
      beat_q    <= '0;
      arvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      araddr_q  <= araddr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      h_q       <= h_d;
      row_q     <= row_d;
      col_q     <= col_d;
      arlen_q   <= arlen_d;
      beat_q    <= beat_d;
      arvalid_q <= arvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

`ifndef AXI_RD_RRESP_CHECK_EN
  logic unused_rresp;
  assign unused_rresp = ^M00_AXI.rresp;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign pixel_valid = (state_q == DATA) && M00_AXI.rvalid;
  assign pixel_data  = 8'(M00_AXI.rdata >> {lane, 3'b000});
  assign pixel_eol   = pixel_valid && exp_last && row_end;
  assign pixel_last  = pixel_eol && at_last_row;

  assign M00_AXI.araddr  = araddr_q;
  assign M00_AXI.arlen   = arlen_q;
  assign M00_AXI.arsize  = 3'b000;
  assign M00_AXI.arburst = 2'b01;
  assign M00_AXI.arlock  = 2'b00;
  assign M00_AXI.arcache = 4'b0011;
  assign M00_AXI.arprot  = 3'b000;
  assign M00_AXI.arqos   = 4'b0000;
  assign M00_AXI.arvalid = arvalid_q;
  assign M00_AXI.rready  = (state_q == DATA) && pixel_ready;
endmodule

// File: tb/tb_axi_burst_reader_axi3.sv
// Randomized bench for axi_burst_reader_axi3: AXI slave model, pixel sink,
// and a rectangle-level reference model of expected bursts and pixels.
module tb_axi_burst_reader_axi3;
  localparam int STRIDE = 800;
  localparam int MAXB   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fb_base;
  logic [10:0] px, py, w, h;
  logic        start;
  logic        busy, done, error;
  logic [7:0]  pixel_data;
  logic        pixel_valid, pixel_ready, pixel_eol, pixel_last;

  always #5 clk = ~clk;

  axi_burst_reader_axi3_if axi();

  axi_burst_reader_axi3 #(.STRIDE(STRIDE), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .reset(reset),
    .framebuffer_baseaddr(fb_base),
    .pixel_x(px), .pixel_y(py), .width(w), .height(h),
    .start(start), .busy(busy), .done(done), .error(error),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .pixel_eol(pixel_eol),
    .pixel_last(pixel_last), .M00_AXI(axi.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_addr[$], obs_addr[$];
  logic [3:0]  exp_len[$],  obs_len[$];
  logic [9:0]  exp_pix[$],  obs_pix[$];
  int          done_cnt, proto_err;
  bit          timeout, aborted;
  logic        err_done;

  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [7:0] t;
    t = a[7:0] * 8'd37;
    return t ^ a[15:8] ^ {a[1:0], a[23:18]} ^ a[31:24];
  endfunction

  function automatic logic [31:0] wd(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:2], 2'b00};
    return {mb(b + 32'd3), mb(b + 32'd2), mb(b + 32'd1), mb(b)};
  endfunction

  // Expected bursts and pixel stream straight from the rectangle rules
  task automatic build_model(input logic [31:0] b, input logic [10:0] x, y, ww, hh);
    logic [31:0] ra, a;
    int col, beats, lim;
    logic eol, lst;
    exp_addr.delete(); exp_len.delete(); exp_pix.delete();
    for (int r = 0; r <= int'(hh); r++) begin
      ra = b + (32'(y) + 32'(r)) * 32'(STRIDE) + 32'(x);
      col = 0;
      while (col <= int'(ww)) begin
        a = ra + 32'(col);
        beats = int'(ww) + 1 - col;
        if (beats > MAXB) beats = MAXB;
        lim = 4096 - int'(a[11:0]);
        if (lim < beats) beats = lim;
        exp_addr.push_back(a);
        exp_len.push_back(4'(beats - 1));
        for (int i = 0; i < beats; i++) begin
          eol = (col + i == int'(ww));
          lst = eol && (r == int'(hh));
          exp_pix.push_back({lst, eol, mb(a + 32'(i))});
        end
        col += beats;
      end
    end
  endtask

  function automatic int diff_bursts();
    int d = 0;
    if (obs_addr.size() != exp_addr.size()) return 1000 + obs_addr.size();
    foreach (exp_addr[i])
      if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i]) d++;
    return d;
  endfunction

  function automatic int diff_pixels();
    int d = 0;
    if (obs_pix.size() != exp_pix.size()) return 1000 + obs_pix.size();
    foreach (exp_pix[i])
      if (obs_pix[i] !== exp_pix[i]) d++;
    return d;
  endfunction

  // Drives one rectangle: AXI slave, pixel sink, protocol monitor
  task automatic run_rect(input logic [31:0] b, input logic [10:0] x, y, ww, hh,
                          input int err_beat, input int early_burst,
                          input int stall_at, input int abort_at);
    int cyc, nbeat, stall_left, s_idx;
    bit s_have, ar_wait, seen_done, hs_r;
    logic [31:0] s_addr, ar_a;
    logic [3:0] s_len, ar_l;
    obs_addr.delete(); obs_len.delete(); obs_pix.delete();
    done_cnt = 0; proto_err = 0; timeout = 0; aborted = 0; err_done = 1'bx;
    cyc = 0; nbeat = 0; stall_left = 0; s_idx = 0;
    s_have = 0; ar_wait = 0; seen_done = 0;
    s_addr = '0; s_len = '0; ar_a = '0; ar_l = '0;
    @(posedge clk); #1;
    fb_base = b; px = x; py = y; w = ww; h = hh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fb_base = $urandom; px = 11'($urandom); py = 11'($urandom);
    w = 11'($urandom); h = 11'($urandom);
    while (1) begin
      @(negedge clk);
      if (seen_done) begin
        if (busy !== 1'b0 || done !== 1'b0) proto_err++;
        break;
      end
      if (busy !== 1'b1) proto_err++;
      if (axi.rready && (!pixel_ready || !s_have)) proto_err++;
      if (axi.rready && (pixel_valid !== axi.rvalid)) proto_err++;
      if (pixel_valid && !axi.rvalid) proto_err++;
      if (ar_wait && (axi.arvalid !== 1'b1 || axi.araddr !== ar_a || axi.arlen !== ar_l))
        proto_err++;
      ar_wait = axi.arvalid && !axi.arready;
      ar_a = axi.araddr; ar_l = axi.arlen;
      if (axi.arvalid && axi.arready) begin
        obs_addr.push_back(axi.araddr);
        obs_len.push_back(axi.arlen);
        if (axi.arsize !== 3'd0 || axi.arburst !== 2'b01 || axi.arcache !== 4'b0011)
          proto_err++;
        s_have = 1; s_addr = axi.araddr; s_len = axi.arlen; s_idx = 0;
      end
      hs_r = axi.rvalid && axi.rready;
      if (hs_r) begin
        if (pixel_valid) obs_pix.push_back({pixel_last, pixel_eol, pixel_data});
        else proto_err++;
        if (stall_at >= 0 && obs_pix.size() == stall_at) stall_left = 5;
        nbeat++; s_idx++;
        if (axi.rlast) s_have = 0;
      end
      if (done) begin
        done_cnt++; err_done = error; seen_done = 1;
      end
      if (abort_at >= 0 && nbeat >= abort_at && axi.rvalid && !hs_r) begin
        #2 reset = 1'b1;
        #1 aborted = 1;
        break;
      end
      cyc++;
      if (cyc > 20000) begin timeout = 1; break; end
      @(posedge clk); #1;
      if (!seen_done && $urandom_range(0, 15) == 0) begin
        start = 1'b1; fb_base = $urandom; px = 11'($urandom);
      end else begin
        start = 1'b0;
      end
      axi.arready = axi.arvalid && !s_have && ($urandom_range(0, 2) != 0);
      if (!(axi.rvalid && !hs_r)) begin
        if (s_have && $urandom_range(0, 3) != 0) begin
          axi.rvalid = 1'b1;
          axi.rdata  = wd(s_addr + 32'(s_idx));
          axi.rlast  = (early_burst == obs_addr.size() - 1) ? (s_idx == 0)
                                                             : (s_idx == int'(s_len));
          axi.rresp  = (nbeat == err_beat) ? 2'b10 : 2'b00;
        end else begin
          axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
          axi.rdata  = $urandom;
        end
      end
      if (stall_left > 0) begin
        pixel_ready = 1'b0; stall_left--;
      end else begin
        pixel_ready = ($urandom_range(0, 3) != 0);
      end
    end
    start = 1'b0;
    if (!aborted) begin
      axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.arready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b want 0", error); end
    n_tests++; if (axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b want 0", axi.arvalid); end
    n_tests++; if (axi.araddr !== 32'd0) begin n_fail++; $display("FAIL rst_araddr: got %h want 0", axi.araddr); end
    n_tests++; if (axi.arlen !== 4'd0) begin n_fail++; $display("FAIL rst_arlen: got %0d want 0", axi.arlen); end
    n_tests++; if (axi.rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready: got %b want 0", axi.rready); end
    n_tests++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pvalid: got %b want 0", pixel_valid); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_single_burst();
    int dp;
    build_model(32'h1000_0000, 11'd10, 11'd2, 11'd3, 11'd0);
    run_rect(32'h1000_0000, 11'd10, 11'd2, 11'd3, 11'd0, -1, -1, -1, -1);
    dp = diff_pixels();
    n_tests++; if (timeout !== 1'b0 || done_cnt !== 1) begin n_fail++; $display("FAIL single_done: done_cnt=%0d timeout=%0d want 1/0", done_cnt, timeout); end
    n_tests++; if (obs_addr.size() != 1 || obs_addr[0] !== 32'h1000_064A || obs_len[0] !== 4'd3) begin
      n_fail++; $display("FAIL single_ar: bursts=%0d addr=%h len=%0d want 1/1000064a/3", obs_addr.size(), obs_addr.size() ? obs_addr[0] : 32'd0, obs_len.size() ? obs_len[0] : 4'd0); end
    n_tests++; if (obs_pix.size() != 4 || obs_pix[3][9:8] !== 2'b11) begin n_fail++; $display("FAIL single_eol_last: pixels=%0d want 4 with eol+last on 4th", obs_pix.size()); end
    n_tests++; if (dp !== 0) begin n_fail++; $display("FAIL single_pixels: diffs=%0d want 0", dp); end
    n_tests++; if (proto_err !== 0) begin n_fail++; $display("FAIL single_proto: violations=%0d want 0", proto_err); end
    n_tests++; if (err_done !== 1'b0) begin n_fail++; $display("FAIL single_error: got %b want 0", err_done); end
  endtask

  task automatic test_multi_row();
    int dp, db;
    build_model(32'h1000_0000, 11'd10, 11'd2, 11'd39, 11'd1);
    run_rect(32'h1000_0000, 11'd10, 11'd2, 11'd39, 11'd1, -1, -1, -1, -1);
    dp = diff_pixels(); db = diff_bursts();
    n_tests++; if (obs_len.size() != 6 || obs_len[0] !== 4'd15 || obs_len[1] !== 4'd15 || obs_len[2] !== 4'd7 || obs_len[5] !== 4'd7) begin
      n_fail++; $display("FAIL multi_lens: bursts=%0d want 6 with lens 15,15,7 per row", obs_len.size()); end
    n_tests++; if (obs_addr.size() != 6 || obs_addr[3] - obs_addr[0] !== 32'd800) begin n_fail++; $display("FAIL multi_stride: bursts=%0d want row step 800", obs_addr.size()); end
    n_tests++; if (obs_pix.size() != 80) begin n_fail++; $display("FAIL multi_count: got %0d want 80", obs_pix.size()); end
    n_tests++; if (db !== 0 || dp !== 0) begin n_fail++; $display("FAIL multi_model: burst diffs=%0d pixel diffs=%0d want 0", db, dp); end
    n_tests++; if (done_cnt !== 1 || proto_err !== 0) begin n_fail++; $display("FAIL multi_done: done=%0d proto=%0d want 1/0", done_cnt, proto_err); end
  endtask

  task automatic test_4k_boundary();
    int dp;
    build_model(32'h1000_0FFA, 11'd0, 11'd0, 11'd15, 11'd0);
    run_rect(32'h1000_0FFA, 11'd0, 11'd0, 11'd15, 11'd0, -1, -1, -1, -1);
    dp = diff_pixels();
    n_tests++; if (obs_addr.size() != 2 || obs_addr[0] !== 32'h1000_0FFA || obs_len[0] !== 4'd5 || obs_addr[1] !== 32'h1000_1000 || obs_len[1] !== 4'd9) begin
      n_fail++; $display("FAIL 4k_split: bursts=%0d want 2 (ffa/len5, 1000/len9)", obs_addr.size()); end
    n_tests++; if (dp !== 0 || done_cnt !== 1) begin n_fail++; $display("FAIL 4k_pixels: diffs=%0d done=%0d want 0/1", dp, done_cnt); end
  endtask

  task automatic test_backpressure();
    int dp, db;
    logic [31:0] b;
    b = $urandom;
    build_model(b, 11'd37, 11'd5, 11'd23, 11'd1);
    run_rect(b, 11'd37, 11'd5, 11'd23, 11'd1, -1, -1, 6, -1);
    dp = diff_pixels(); db = diff_bursts();
    n_tests++; if (obs_pix.size() != 48) begin n_fail++; $display("FAIL bp_count: got %0d want 48", obs_pix.size()); end
    n_tests++; if (dp !== 0 || db !== 0) begin n_fail++; $display("FAIL bp_order: pixel diffs=%0d burst diffs=%0d want 0", dp, db); end
    n_tests++; if (proto_err !== 0) begin n_fail++; $display("FAIL bp_proto: violations=%0d want 0", proto_err); end
  endtask

  task automatic test_rresp();
    int dp;
    logic exp_err;
`ifdef AXI_RD_RRESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    build_model(32'h0000_2000, 11'd3, 11'd1, 11'd7, 11'd0);
    run_rect(32'h0000_2000, 11'd3, 11'd1, 11'd7, 11'd0, 2, -1, -1, -1);
    dp = diff_pixels();
    n_tests++; if (err_done !== exp_err) begin n_fail++; $display("FAIL rresp_error: got %b want %b", err_done, exp_err); end
    n_tests++; if (dp !== 0 || done_cnt !== 1) begin n_fail++; $display("FAIL rresp_complete: diffs=%0d done=%0d want 0/1", dp, done_cnt); end
    build_model(32'h0000_3000, 11'd0, 11'd0, 11'd4, 11'd0);
    run_rect(32'h0000_3000, 11'd0, 11'd0, 11'd4, 11'd0, -1, -1, -1, -1);
    n_tests++; if (err_done !== 1'b0) begin n_fail++; $display("FAIL rresp_clear: got %b want 0", err_done); end
  endtask

  task automatic test_rlast_early();
    int db;
    build_model(32'h2000_0000, 11'd0, 11'd0, 11'd39, 11'd0);
    run_rect(32'h2000_0000, 11'd0, 11'd0, 11'd39, 11'd0, -1, 0, -1, -1);
    db = diff_bursts();
    n_tests++; if (err_done !== 1'b1) begin n_fail++; $display("FAIL rlast_error: got %b want 1", err_done); end
    n_tests++; if (db !== 0 || obs_pix.size() != 25) begin n_fail++; $display("FAIL rlast_continue: burst diffs=%0d pixels=%0d want 0/25", db, obs_pix.size()); end
    n_tests++; if (done_cnt !== 1 || timeout !== 1'b0) begin n_fail++; $display("FAIL rlast_done: done=%0d timeout=%0d want 1/0", done_cnt, timeout); end
  endtask

  task automatic test_reset_mid();
    int dp, db;
    logic [31:0] b;
    b = $urandom;
    run_rect(b, 11'd100, 11'd7, 11'd31, 11'd1, -1, -1, -1, 3);
    n_tests++; if (aborted !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach: aborted=%b want 1", aborted); end
    n_tests++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: arvalid=%b rready=%b busy=%b want 0/0/0", axi.arvalid, axi.rready, busy); end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.arready = 1'b0; start = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    b = $urandom;
    build_model(b, 11'd4, 11'd9, 11'd20, 11'd2);
    run_rect(b, 11'd4, 11'd9, 11'd20, 11'd2, -1, -1, -1, -1);
    dp = diff_pixels(); db = diff_bursts();
    n_tests++; if (dp !== 0 || db !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL rstmid_refetch: pixel diffs=%0d burst diffs=%0d done=%0d want 0/0/1", dp, db, done_cnt); end
  endtask

  task automatic test_back_to_back();
    int dp, db;
    logic [31:0] b;
    for (int k = 0; k < 2; k++) begin
      b = $urandom;
      build_model(b, 11'(k * 5), 11'd1, 11'(3 + k), 11'd1);
      run_rect(b, 11'(k * 5), 11'd1, 11'(3 + k), 11'd1, -1, -1, -1, -1);
      dp = diff_pixels(); db = diff_bursts();
      n_tests++; if (dp !== 0 || db !== 0 || done_cnt !== 1 || proto_err !== 0) begin
        n_fail++; $display("FAIL b2b_%0d: pixel diffs=%0d burst diffs=%0d done=%0d proto=%0d want 0/0/1/0", k, dp, db, done_cnt, proto_err); end
    end
  endtask

  task automatic test_random();
    int dp, db;
    logic [31:0] b;
    logic [10:0] x, y, ww, hh;
    for (int k = 0; k < 6; k++) begin
      b = $urandom;
      if ($urandom_range(0, 1) == 1) b[11:4] = 8'hFF;
      x = 11'($urandom); y = 11'($urandom);
      ww = 11'($urandom_range(0, 47)); hh = 11'($urandom_range(0, 3));
      build_model(b, x, y, ww, hh);
      run_rect(b, x, y, ww, hh, -1, -1, -1, -1);
      dp = diff_pixels(); db = diff_bursts();
      n_tests++; if (dp !== 0 || db !== 0 || done_cnt !== 1 || proto_err !== 0 || err_done !== 1'b0) begin
        n_fail++; $display("FAIL rand_%0d: base=%h w=%0d h=%0d pixel diffs=%0d burst diffs=%0d done=%0d proto=%0d err=%b want 0/0/1/0/0",
                           k, b, ww, hh, dp, db, done_cnt, proto_err, err_done); end
    end
  endtask

  initial begin
    fb_base = '0; px = '0; py = '0; w = '0; h = '0; start = 1'b0;
    pixel_ready = 1'b1;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
    axi.rresp = 2'b00; axi.rlast = 1'b0;
    test_reset();
    test_single_burst();
    test_multi_row();
    test_4k_boundary();
    test_backpressure();
    test_rresp();
    test_rlast_early();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
